spi_shift_engine: RTL and testbench

Parametrised full-duplex SPI master shift engine. It combines the separate transmit and receive shift registers into one block and generates its own SCLK and chip select from clk_i. Word width, SPI mode (CPOL/CPHA), bit order and SCLK rate are all configurable. It sits between the bus-side controller, which issues start_i and tx_data_i, and the SPI pins of one slave.

---
 rtl/spi_shift_engine.sv | 159 +++++++++++++++
 tb/tb_spi_shift_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine: one tx and one rx shift register, with SCLK and
// chip select generated locally from clk_i. Mode, bit order, width and SCLK rate are parameters.
module spi_shift_engine #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit CPOL      = 1'b1,
  parameter bit CPHA      = 1'b1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rxData_q, rxData_d;
  logic [BIT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              csn_q, csn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic divWrap, leadEdge, lastEdge, sampleEdge, driveEdge;

  function automatic logic firstBit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shiftOut(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shiftIn(input logic [DATA_W-1:0] w, input logic b);
    return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // The edge about to happen is leading when SCLK still sits at its idle level.
  assign divWrap    = (div_q == DIV_LAST);
  assign leadEdge   = (sclk_q == CPOL);
  assign lastEdge   = !leadEdge && (bitCnt_q == BIT_LAST);
  assign sampleEdge = CPHA ? !leadEdge : leadEdge;
  assign driveEdge  = CPHA ? leadEdge : (!leadEdge && !lastEdge);

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxData_d = rxData_q;
    bitCnt_d = bitCnt_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    csn_d    = csn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_d     = tx_data_i;
          rx_d     = '0;
          bitCnt_d = '0;
          div_d    = '0;
          csn_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = LEAD;
          if (!CPHA) begin
            mosi_d = firstBit(tx_data_i);
            tx_d   = shiftOut(tx_data_i);
          end
        end
      end
      LEAD, SHIFT: begin
        if (divWrap) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sampleEdge) rx_d = shiftIn(rx_q, miso_i);
          if (driveEdge) begin
            mosi_d = firstBit(tx_q);
            tx_d   = shiftOut(tx_q);
          end
          if (!leadEdge) bitCnt_d = bitCnt_q + BIT_W'(1);
          if (state_q == LEAD) state_d = SHIFT;
          else if (lastEdge)   state_d = TRAIL;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (divWrap) begin
          div_d    = '0;
          state_d  = IDLE;
          csn_d    = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          mosi_d   = 1'b0;
          rxData_d = rx_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      rxData_q <= '0;
      bitCnt_q <= '0;
      div_q    <= '0;
      sclk_q   <= CPOL;
      mosi_q   <= 1'b0;
      csn_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxData_q <= rxData_d;
      bitCnt_q <= bitCnt_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      csn_q    <= csn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rx_data_o = rxData_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = csn_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: three configurations driven from one clock, a cycle-level
// model of busy/cs_n/done/rx_data per instance, and a scoreboard of words per transfer.
module tb_spi_shift_engine;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  tx0 = '0, tx1 = '0;
  logic [15:0] tx2 = '0;
  logic [7:0]  rx0, rx1;
  logic [15:0] rx2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic sclk0, sclk1, sclk2, mosi0, mosi1, mosi2;
  logic csn0, csn1, csn2, miso0, miso1, miso2;

  localparam logic [7:0] SLAVE_WORD = 8'h3C;
  localparam int LAT  [3] = '{35, 35, 34};
  localparam int WID  [3] = '{8, 8, 16};
  localparam bit POL  [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit LSBF [3] = '{1'b0, 1'b0, 1'b1};

  assign miso0 = mosi0;
  assign miso2 = mosi2;

  spi_shift_engine #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u0 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start0), .tx_data_i(tx0), .rx_data_o(rx0),
    .busy_o(busy0), .done_o(done0), .sclk_o(sclk0), .mosi_o(mosi0), .miso_i(miso0), .cs_n_o(csn0));

  spi_shift_engine #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u1 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start1), .tx_data_i(tx1), .rx_data_o(rx1),
    .busy_o(busy1), .done_o(done1), .sclk_o(sclk1), .mosi_o(mosi1), .miso_i(miso1), .cs_n_o(csn1));

  spi_shift_engine #(.DATA_W(16), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u2 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start2), .tx_data_i(tx2), .rx_data_o(rx2),
    .busy_o(busy2), .done_o(done2), .sclk_o(sclk2), .mosi_o(mosi2), .miso_i(miso2), .cs_n_o(csn2));

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] rx;
    logic [15:0] tx;
  } sbEntry_t;
  sbEntry_t sbQ0[$], sbQ1[$], sbQ2[$];

  bit          mBusy    [3] = '{0, 0, 0};
  bit          mDone    [3] = '{0, 0, 0};
  logic [15:0] mRx      [3] = '{0, 0, 0};
  int          mDoneCyc [3] = '{0, 0, 0};
  logic [15:0] cap      [3] = '{0, 0, 0};
  int          riseCnt  [3] = '{0, 0, 0};
  logic [15:0] curTx    [3] = '{0, 0, 0};
  int          doneCnt  [3] = '{0, 0, 0};
  logic [7:0]  sOut = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] maskOf(input int id);
    return (WID[id] == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Slave-side capture on every SCLK rising edge, which is the sample edge in all three modes.
  task automatic sampleBit(input int id, input logic b);
    logic [15:0] t;
    if (riseCnt[id] == 0) begin
      t = curTx[id];
      checkOutput($sformatf("u%0d first mosi", id), 32'(b), 32'(LSBF[id] ? t[0] : t[WID[id]-1]));
    end
    if (LSBF[id]) cap[id] = {b, cap[id][15:1]};
    else          cap[id] = {cap[id][14:0], b};
    riseCnt[id]++;
  endtask

  always @(posedge sclk0) if (rstn && !csn0) sampleBit(0, mosi0);
  always @(posedge sclk1) if (rstn && !csn1) sampleBit(1, mosi1);
  always @(posedge sclk2) if (rstn && !csn2) sampleBit(2, mosi2);

  // Slave for u1 (mode 0): first bit valid when selected, next bit after each falling edge.
  always @(negedge csn1) begin
    sOut  = SLAVE_WORD;
    miso1 = sOut[7];
  end
  always @(negedge sclk1) if (rstn && !csn1) begin
    sOut  = {sOut[6:0], 1'b0};
    miso1 = sOut[7];
  end
  initial miso1 = 1'b0;

  task automatic modelStep(input int id, input logic startV, input logic [15:0] txV,
                           input logic busyV, input logic csnV, input logic doneV,
                           input logic sclkV, input logic mosiV, input logic [15:0] rxV);
    sbEntry_t e;
    bit got;
    if (!rstn) begin
      mBusy[id] = 0;
      mDone[id] = 0;
      mRx[id]   = '0;
      case (id)
        0: sbQ0.delete();
        1: sbQ1.delete();
        default: sbQ2.delete();
      endcase
      checkOutput($sformatf("u%0d rst busy", id), 32'(busyV), 0);
      checkOutput($sformatf("u%0d rst cs_n", id), 32'(csnV), 1);
      checkOutput($sformatf("u%0d rst done", id), 32'(doneV), 0);
      checkOutput($sformatf("u%0d rst sclk", id), 32'(sclkV), 32'(POL[id]));
      checkOutput($sformatf("u%0d rst mosi", id), 32'(mosiV), 0);
      checkOutput($sformatf("u%0d rst rx", id), 32'(rxV), 0);
      return;
    end
    mDone[id] = 0;
    if (mBusy[id] && cyc == mDoneCyc[id]) begin
      mBusy[id] = 0;
      mDone[id] = 1;
      doneCnt[id]++;
      got = 0;
      case (id)
        0: if (sbQ0.size() > 0) begin e = sbQ0.pop_front(); got = 1; end
        1: if (sbQ1.size() > 0) begin e = sbQ1.pop_front(); got = 1; end
        default: if (sbQ2.size() > 0) begin e = sbQ2.pop_front(); got = 1; end
      endcase
      checkOutput($sformatf("u%0d scoreboard entry", id), 32'(got), 1);
      if (got) begin
        mRx[id] = e.rx;
        checkOutput($sformatf("u%0d slave word", id), 32'(cap[id] & maskOf(id)), 32'(e.tx));
        checkOutput($sformatf("u%0d sclk periods", id), 32'(riseCnt[id]), 32'(WID[id]));
      end
    end
    checkOutput($sformatf("u%0d busy", id), 32'(busyV), 32'(mBusy[id]));
    checkOutput($sformatf("u%0d cs_n", id), 32'(csnV), 32'(!mBusy[id]));
    checkOutput($sformatf("u%0d done", id), 32'(doneV), 32'(mDone[id]));
    checkOutput($sformatf("u%0d rx_data", id), 32'(rxV), 32'(mRx[id]));
    if (!mBusy[id]) begin
      checkOutput($sformatf("u%0d idle sclk", id), 32'(sclkV), 32'(POL[id]));
      checkOutput($sformatf("u%0d idle mosi", id), 32'(mosiV), 0);
    end
    if (startV && !mBusy[id]) begin
      mBusy[id]    = 1;
      mDoneCyc[id] = cyc + LAT[id];
      e.tx         = txV & maskOf(id);
      e.rx         = (id == 1) ? {8'h00, SLAVE_WORD} : e.tx;
      curTx[id]    = e.tx;
      cap[id]      = '0;
      riseCnt[id]  = 0;
      case (id)
        0: sbQ0.push_back(e);
        1: sbQ1.push_back(e);
        default: sbQ2.push_back(e);
      endcase
    end
  endtask

  always @(negedge clk) modelStep(0, start0, {8'h00, tx0}, busy0, csn0, done0, sclk0, mosi0, {8'h00, rx0});
  always @(negedge clk) modelStep(1, start1, {8'h00, tx1}, busy1, csn1, done1, sclk1, mosi1, {8'h00, rx1});
  always @(negedge clk) modelStep(2, start2, tx2, busy2, csn2, done2, sclk2, mosi2, rx2);

  task automatic applyStimulus(input int id, input logic [15:0] tx);
    @(posedge clk); #1;
    case (id)
      0: begin start0 = 1'b1; tx0 = tx[7:0]; end
      1: begin start1 = 1'b1; tx1 = tx[7:0]; end
      default: begin start2 = 1'b1; tx2 = tx; end
    endcase
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(0, 16'h00A5);
    repeat (40) @(posedge clk);
    applyStimulus(1, 16'h00C3);
    repeat (40) @(posedge clk);
    applyStimulus(2, 16'h1234);
    repeat (40) @(posedge clk);

    d0 = doneCnt[0];
    @(posedge clk); #1;
    start0 = 1'b1;
    tx0 = 8'h11;
    repeat (5) @(posedge clk);
    #1 tx0 = 8'h22;
    repeat (31) @(posedge clk);
    #1 start0 = 1'b0;
    repeat (40) @(posedge clk);
    checkOutput("u0 back-to-back done count", 32'(doneCnt[0] - d0), 2);

    d0 = doneCnt[0];
    applyStimulus(0, 16'h005A);
    repeat (8) @(posedge clk);
    #1 begin start0 = 1'b1; tx0 = 8'hFF; end
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (40) @(posedge clk);
    checkOutput("u0 ignored start done count", 32'(doneCnt[0] - d0), 1);

    d0 = doneCnt[0];
    applyStimulus(0, 16'h003C);
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkOutput("abort cs_n", 32'(csn0), 1);
    checkOutput("abort sclk", 32'(sclk0), 1);
    checkOutput("abort busy", 32'(busy0), 0);
    checkOutput("abort rx_data", 32'(rx0), 0);
    checkOutput("abort done", 32'(done0), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (40) @(posedge clk);
    checkOutput("abort no done", 32'(doneCnt[0] - d0), 0);
    applyStimulus(0, 16'h0096);
    repeat (40) @(posedge clk);
    checkOutput("after abort done count", 32'(doneCnt[0] - d0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
